// File: rtl/ipsxe_fft_spectrum_buf.sv
// FFT output spectrum buffer: approximate |X[k]| per bin, saturated, stored per frame in a
// ping-pong RAM; the readout client sees the last complete, correctly sized frame.
module ipsxe_fft_spectrum_buf #(
  parameter int unsigned LOG2_FFT_LEN = 10,
  parameter int unsigned DATA_WIDTH   = 27,
  parameter int unsigned BYTE_WIDTH   = 32,
  parameter int unsigned USER_WIDTH   = 16,
  parameter int unsigned MAG_WIDTH    = 16,
  parameter int unsigned MAG_SHIFT    = 11
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_aclken,
  input  logic                    i_axi4s_data_tvalid,
  input  logic [2*BYTE_WIDTH-1:0] i_axi4s_data_tdata,
  input  logic                    i_axi4s_data_tlast,
  input  logic [USER_WIDTH-1:0]   i_axi4s_data_tuser,
  input  logic                    i_rd_lock,
  input  logic                    i_rd_en,
  input  logic [LOG2_FFT_LEN-1:0] i_rd_addr,
  output logic [MAG_WIDTH-1:0]    o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_frame_valid,
  output logic                    o_frame_done,
  output logic                    o_len_err,
  output logic [7:0]              o_drop_cnt
);

  localparam int unsigned FftLen = 1 << LOG2_FFT_LEN;
  localparam int unsigned CntW   = LOG2_FFT_LEN + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FftLen - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FftLen);
  localparam logic [DATA_WIDTH:0] MagMax = (DATA_WIDTH + 1)'({MAG_WIDTH{1'b1}});

  logic [DATA_WIDTH-1:0] in_re, in_im, re_abs, im_abs;
  logic                  unused_in;

  assign in_re  = i_axi4s_data_tdata[DATA_WIDTH-1:0];
  assign in_im  = i_axi4s_data_tdata[BYTE_WIDTH +: DATA_WIDTH];
  // Two's-complement negate as unsigned: the most negative input becomes 2**(DATA_WIDTH-1).
  assign re_abs = in_re[DATA_WIDTH-1] ? (~in_re + DATA_WIDTH'(1)) : in_re;
  assign im_abs = in_im[DATA_WIDTH-1] ? (~in_im + DATA_WIDTH'(1)) : in_im;
  assign unused_in = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

  logic                    s1_vld_q, s2_vld_q, s3_vld_q;
  logic                    s1_last_q, s2_last_q, s3_last_q;
  logic [LOG2_FFT_LEN-1:0] s1_idx_q, s2_idx_q, s3_idx_q;
  logic [DATA_WIDTH-1:0]   s1_re_q, s1_im_q, s2_mx_q, s2_mn_q;
  logic [DATA_WIDTH:0]     s3_mag_q, mag_shift;
  logic [MAG_WIDTH-1:0]    mag_sat;
  logic                    wr_fire;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
      s3_last_q <= 1'b0;
    end else if (i_aclken) begin
      s1_vld_q  <= i_axi4s_data_tvalid;
      s1_last_q <= i_axi4s_data_tlast;
      s1_idx_q  <= i_axi4s_data_tuser[LOG2_FFT_LEN-1:0];
      s1_re_q   <= re_abs;
      s1_im_q   <= im_abs;
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_idx_q  <= s1_idx_q;
      s2_mx_q   <= (s1_re_q >= s1_im_q) ? s1_re_q : s1_im_q;
      s2_mn_q   <= (s1_re_q >= s1_im_q) ? s1_im_q : s1_re_q;
      s3_vld_q  <= s2_vld_q;
      s3_last_q <= s2_last_q;
      s3_idx_q  <= s2_idx_q;
      s3_mag_q  <= {1'b0, s2_mx_q} + {1'b0, s2_mn_q >> 2} + {1'b0, s2_mn_q >> 3};
    end
  end

  assign mag_shift = s3_mag_q >> MAG_SHIFT;
  assign mag_sat   = (mag_shift > MagMax) ? {MAG_WIDTH{1'b1}} : mag_shift[MAG_WIDTH-1:0];
  assign wr_fire   = i_aclken & s3_vld_q & i_rstn;

  // Frame accounting and bank control; bank_q is the write bank, the read bank is its complement.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bad_q, bad_d, bank_q, bank_d;
  logic            frame_valid_q, frame_valid_d, done_q, done_d, len_err_q, len_err_d;
  logic [7:0]      drop_q, drop_d;
  logic            frame_good;

  assign frame_good = (cnt_q == LastCnt) && !bad_q;

  always_comb begin
    cnt_d         = cnt_q;
    bad_d         = bad_q;
    bank_d        = bank_q;
    frame_valid_d = frame_valid_q;
    done_d        = 1'b0;
    len_err_d     = len_err_q;
    drop_d        = drop_q;
    if (wr_fire) begin
      if (s3_last_q) begin
        cnt_d = '0;
        bad_d = 1'b0;
        if (!frame_good) begin
          len_err_d = 1'b1;
        end else if (i_rd_lock) begin
          if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
        end else begin
          bank_d        = ~bank_q;
          done_d        = 1'b1;
          frame_valid_d = 1'b1;
        end
      end else begin
        if (cnt_q != FullCnt) cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q         <= '0;
      bad_q         <= 1'b0;
      bank_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      done_q        <= 1'b0;
      len_err_q     <= 1'b0;
      drop_q        <= '0;
    end else begin
      cnt_q         <= cnt_d;
      bad_q         <= bad_d;
      bank_q        <= bank_d;
      frame_valid_q <= frame_valid_d;
      done_q        <= done_d;
      len_err_q     <= len_err_d;
      drop_q        <= drop_d;
    end
  end

  logic [MAG_WIDTH-1:0] mem [2*FftLen];
  logic [MAG_WIDTH-1:0] rd_data_q;
  logic                 rd_valid_q;

  always_ff @(posedge i_clk) begin
    if (wr_fire) mem[{bank_q, s3_idx_q}] <= mag_sat;
  end

  // Reads use the pre-edge bank_q, so a read coincident with a swap returns the old frame.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= i_rd_en;
      if (i_rd_en) rd_data_q <= mem[{~bank_q, i_rd_addr}];
    end
  end

  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_frame_valid = frame_valid_q;
  assign o_frame_done  = done_q;
  assign o_len_err     = len_err_q;
  assign o_drop_cnt    = drop_q;

endmodule
